// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: synchronises rx, frames start/data/stop bits at mid-bit,
// and hands bytes to a one-entry valid/ready buffer with overrun tracking.
module uart_rx_framer #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    input  logic       clr_i,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;

    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;

    // Synchroniser resets to all-ones so the line reads idle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        if (ce) begin
            unique case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        cnt_d   = HALF_LOAD;
                        state_d = START;
                    end
                end
                START: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 16'd1;
                    end else if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = '0;
                        cnt_d   = BIT_LOAD;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 16'd1;
                    end else begin
                        shift_d[idx_q] = rxs;
                        cnt_d          = BIT_LOAD;
                        if (idx_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 16'd1;
                    end else if (rxs) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // The buffer acts on the registered completion, one cycle after the stop
    // sample, and is independent of ce so consumers can always drain it.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (clr_i) begin
            ovr_d = 1'b0;
        end
        if (done_q) begin
            if (!valid_q || ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- UART receiver (8N1, LSB first) that deserialises the CPU's serial line into bytes.
- Sits between a pad input (rx pin) and byte consumers: the bootloader's program-load path, or a bench/host monitor on the CPU tx line.
- Handles start-bit validation, mid-bit sampling, stop-bit/framing checks and a one-byte output buffer with valid/ready handshake and overrun detection.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per bit period. Legal range 4..65535.
- SYNC_STAGES, 2, flip-flop depth of the rx input synchroniser. Legal range 2..3.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ce  input  1  clock enable; when 0, the bit FSM and baud counter freeze
- rx  input  1  serial line, idle high, asynchronous to clk
- data_o  output  8  received byte, stable while valid_o=1
- valid_o  output  1  buffer holds an unread byte
- ready_i  input  1  consumer accepts; transfer occurs when valid_o & ready_i at a rising clk edge
- frame_err_o  output  1  one-cycle pulse when the stop bit samples 0
- overrun_o  output  1  sticky flag; a completed byte was dropped because the buffer was full
- clr_i  input  1  synchronous clear of overrun_o
- busy_o  output  1  FSM not in IDLE

Behaviour:
Reset and synchronisation:
- Reset is asynchronous and active-low, on rst_n. All outputs and the FSM return to reset values immediately when rst_n falls.
- Reset values: data_o=0x00, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0, state=IDLE, baud counter=0, all synchroniser flops=1 (line idle).
- rx passes through SYNC_STAGES flops. The FSM sees only the synchronised bit rxs.

FSM states and transitions (each step occurs only on cycles with ce=1):
- IDLE: when rxs=0, load the counter and go to START.
- START: count CLKS_PER_BIT/2 cycles (integer division).
  - If rxs=1 at the sample point: treat as a glitch and return to IDLE. No flags.
  - If rxs=0: go to DATA with bit index 0.
- DATA: every CLKS_PER_BIT cycles, sample rxs into shift[index]; bit 0 arrives first.
  - After index 7 is sampled, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rxs.
  - rxs=1: byte complete; go to IDLE.
  - rxs=0: pulse frame_err_o for one cycle, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1, then go to IDLE. This prevents a break condition from being decoded as 0x00 frames.

Output buffer:
- On byte complete with valid_o=0, or with valid_o=1 & ready_i=1 in the same cycle: data_o is loaded with the new byte and valid_o=1 next cycle. No overrun in either case.
- On byte complete with valid_o=1 & ready_i=0: the new byte is dropped, data_o is unchanged, and overrun_o is set.
- A transfer without a simultaneous completion clears valid_o next cycle.
- data_o holds its last value after it is consumed.
- overrun_o stays set until clr_i=1 or reset. If clr_i and a new overrun occur in the same cycle, the set wins.

Timing and clock enable:
- Byte-complete latency: valid_o rises exactly 1 cycle after the STOP sample cycle.
- Nominal latency from the rx falling edge to valid_o = SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, with ce=1 throughout.
- With ce=0, the FSM and counter hold.
- The handshake and clr_i remain active regardless of ce.

Other:
- busy_o=1 in START, DATA, STOP and WAIT_HIGH.

Test Plan:
All scenarios use CLKS_PER_BIT=8, SYNC_STAGES=2, ce=1 and ready_i=1 unless stated.
- Send 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) -> valid_o=1 with data_o=0xA5 exactly 2+4+72+1=79 cycles after the rx falling edge; frame_err_o never pulses; overrun_o stays 0.
- Pulse rx low for 2 cycles, then hold it high -> FSM returns to IDLE after the START sample; valid_o=0 and frame_err_o=0 throughout.
- Send 0x3C with the stop bit forced to 0, then hold rx low for 40 cycles, then release it -> exactly one frame_err_o pulse; valid_o stays 0; busy_o=1 until 3 cycles after rx returns high.
- With ready_i=0, send 0x11 then 0x22 -> data_o=0x11 with valid_o=1, and overrun_o=1 after the second stop bit. Then assert ready_i for 1 cycle -> valid_o=0 and data_o stays 0x11. Then assert clr_i -> overrun_o=0.
- Hold ready_i=0 after 0x11, and raise ready_i exactly in the cycle 0x22 completes -> data_o=0x22, valid_o stays 1, overrun_o=0.
- Assert rst_n=0 mid-DATA while sending 0xFF -> all outputs reset immediately and the FSM is IDLE. After release, send 0x5A -> data_o=0x5A received correctly.
